// File: rtl/oup_ulpi_regaccess_pkg.sv
// Shared ULPI register-access constants, state encoding and TX CMD helpers.
package oup_ulpi_pkg;

    localparam logic [1:0] TXCMD_REGW    = 2'b10;
    localparam logic [1:0] TXCMD_REGR    = 2'b11;
    localparam logic [5:0] EXT_ADDR_CODE = 6'h2F;
    localparam logic [7:0] NOOP          = 8'h00;

    typedef enum logic [3:0] {
        S_IDLE    = 4'd0,
        S_CMD     = 4'd1,
        S_EXTADDR = 4'd2,
        S_WDATA   = 4'd3,
        S_STP     = 4'd4,
        S_RD_TURN = 4'd5,
        S_RD_DATA = 4'd6,
        S_RD_BACK = 4'd7,
        S_ABORT   = 4'd8,
        S_RESP    = 4'd9
    } regaccess_state_t;

    // 6'h2F is reserved as the escape code, so it must also go out extended
    function automatic logic is_ext_addr(input logic [7:0] addr);
        return (addr[7:6] != 2'b00) || (addr[5:0] == EXT_ADDR_CODE);
    endfunction

    function automatic logic [7:0] tx_cmd(input logic wr, input logic [7:0] addr);
        logic [5:0] field;
        field = is_ext_addr(addr) ? EXT_ADDR_CODE : addr[5:0];
        return {(wr ? TXCMD_REGW : TXCMD_REGR), field};
    endfunction

endpackage

// File: rtl/oup_ulpi_regaccess_if.sv
// Request/response handshake and ULPI bus signals of the register-access engine.
interface oup_ulpi_regaccess_if;

    logic       req_valid_i;
    logic       req_ready_o;
    logic       req_write_i;
    logic [7:0] req_addr_i;
    logic [7:0] req_wdata_i;
    logic       rsp_valid_o;
    logic [7:0] rsp_rdata_o;
    logic       rsp_err_o;
    logic       ulpi_dir_i;
    logic       ulpi_nxt_i;
    logic [7:0] ulpi_data_i;
    logic [7:0] ulpi_data_o;
    logic       ulpi_data_oe_o;
    logic       ulpi_stp_o;

    modport master (
        output req_valid_i, req_write_i, req_addr_i, req_wdata_i,
        output ulpi_dir_i, ulpi_nxt_i, ulpi_data_i,
        input  req_ready_o, rsp_valid_o, rsp_rdata_o, rsp_err_o,
        input  ulpi_data_o, ulpi_data_oe_o, ulpi_stp_o
    );

    modport slave (
        input  req_valid_i, req_write_i, req_addr_i, req_wdata_i,
        input  ulpi_dir_i, ulpi_nxt_i, ulpi_data_i,
        output req_ready_o, rsp_valid_o, rsp_rdata_o, rsp_err_o,
        output ulpi_data_o, ulpi_data_oe_o, ulpi_stp_o
    );

endinterface

// File: rtl/oup_ulpi_regaccess.sv
// Link-side ULPI register access engine: single register reads/writes as TX CMD
// sequences with nxt throttling, dir turnaround, PHY-abort retry and timeout.
module oup_ulpi_regaccess
    import oup_ulpi_pkg::*;
#(
    parameter int MAX_RETRY   = 3,
    parameter int NXT_TIMEOUT = 255
) (
    input  logic                clk_i,
    input  logic                rst_ni,
    oup_ulpi_regaccess_if.slave bus
);

    localparam int TW = $clog2(NXT_TIMEOUT + 1);
    localparam int RW = $clog2(MAX_RETRY + 2);

    regaccess_state_t state_r;
    regaccess_state_t next_state_s;
    regaccess_state_t after_addr_s;

    logic          wr_r;
    logic [7:0]    addr_r;
    logic [7:0]    wdata_r;
    logic [TW-1:0] tmo_cnt_r;
    logic [RW-1:0] retry_r;
    logic          err_pend_r;
    logic          idle_r;
    logic          rsp_valid_r;
    logic          rsp_err_r;
    logic          stp_r;
    logic [7:0]    rdata_r;
    logic [7:0]    data_r;

    logic          accept_s;
    logic          wait_s;
    logic          tmo_s;
    logic          err_set_s;
    logic          retry_inc_s;
    logic          sel_wr_s;
    logic [7:0]    sel_addr_s;
    logic [7:0]    sel_wdata_s;
    logic [7:0]    data_next_s;

    assign bus.req_ready_o    = idle_r && !bus.ulpi_dir_i;
    assign bus.rsp_valid_o    = rsp_valid_r;
    assign bus.rsp_rdata_o    = rdata_r;
    assign bus.rsp_err_o      = rsp_err_r;
    assign bus.ulpi_data_o    = data_r;
    assign bus.ulpi_stp_o     = stp_r;
    assign bus.ulpi_data_oe_o = !bus.ulpi_dir_i;

    assign accept_s     = idle_r && bus.req_valid_i && !bus.ulpi_dir_i;
    assign wait_s       = (state_r == S_CMD) || (state_r == S_EXTADDR) || (state_r == S_WDATA) ||
                          (state_r == S_RD_TURN) || (state_r == S_RD_BACK) || (state_r == S_ABORT);
    assign tmo_s        = wait_s && (tmo_cnt_r == TW'(NXT_TIMEOUT - 1));
    assign after_addr_s = wr_r ? S_WDATA : S_RD_TURN;

    // Output bytes are registered from the next state, so request fields come
    // straight from the inputs in the accept cycle.
    assign sel_wr_s    = accept_s ? bus.req_write_i : wr_r;
    assign sel_addr_s  = accept_s ? bus.req_addr_i  : addr_r;
    assign sel_wdata_s = accept_s ? bus.req_wdata_i : wdata_r;

    // state register
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_r <= S_IDLE;
        end else begin
            state_r <= next_state_s;
        end
    end

    // next-state logic; a dir rise in a driving state wins over nxt and timeout
    always_comb begin
        next_state_s = state_r;
        err_set_s    = 1'b0;
        retry_inc_s  = 1'b0;
        case (state_r)
            S_IDLE: begin
                if (accept_s) next_state_s = S_CMD;
                else          next_state_s = S_IDLE;
            end
            S_CMD: begin
                if (bus.ulpi_dir_i)      next_state_s = S_ABORT;
                else if (bus.ulpi_nxt_i) next_state_s = is_ext_addr(addr_r) ? S_EXTADDR : after_addr_s;
                else if (tmo_s)          begin next_state_s = S_STP; err_set_s = 1'b1; end
                else                     next_state_s = S_CMD;
            end
            S_EXTADDR: begin
                if (bus.ulpi_dir_i)      next_state_s = S_ABORT;
                else if (bus.ulpi_nxt_i) next_state_s = after_addr_s;
                else if (tmo_s)          begin next_state_s = S_STP; err_set_s = 1'b1; end
                else                     next_state_s = S_EXTADDR;
            end
            S_WDATA: begin
                if (bus.ulpi_dir_i)      next_state_s = S_ABORT;
                else if (bus.ulpi_nxt_i) next_state_s = S_STP;
                else if (tmo_s)          begin next_state_s = S_STP; err_set_s = 1'b1; end
                else                     next_state_s = S_WDATA;
            end
            S_STP: next_state_s = S_RESP;
            S_RD_TURN: begin
                if (bus.ulpi_dir_i) next_state_s = S_RD_DATA;
                else if (tmo_s)     begin next_state_s = S_RESP; err_set_s = 1'b1; end
                else                next_state_s = S_RD_TURN;
            end
            S_RD_DATA: next_state_s = S_RD_BACK;
            S_RD_BACK: begin
                if (!bus.ulpi_dir_i) next_state_s = S_RESP;
                else if (tmo_s)      begin next_state_s = S_RESP; err_set_s = 1'b1; end
                else                 next_state_s = S_RD_BACK;
            end
            S_ABORT: begin
                if (!bus.ulpi_dir_i) begin
                    if (retry_r < RW'(MAX_RETRY)) begin
                        retry_inc_s  = 1'b1;
                        next_state_s = S_CMD;
                    end else begin
                        err_set_s    = 1'b1;
                        next_state_s = S_RESP;
                    end
                end else if (tmo_s) begin
                    err_set_s    = 1'b1;
                    next_state_s = S_RESP;
                end else begin
                    next_state_s = S_ABORT;
                end
            end
            S_RESP:  next_state_s = S_IDLE;
            default: next_state_s = S_IDLE;
        endcase
    end

    // byte to present on the bus in the coming cycle
    always_comb begin
        case (next_state_s)
            S_CMD:     data_next_s = tx_cmd(sel_wr_s, sel_addr_s);
            S_EXTADDR: data_next_s = sel_addr_s;
            S_WDATA:   data_next_s = sel_wdata_s;
            default:   data_next_s = NOOP;
        endcase
    end

    // request latch, retry/timeout counters and pending error
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            wr_r       <= 1'b0;
            addr_r     <= 8'h00;
            wdata_r    <= 8'h00;
            retry_r    <= '0;
            tmo_cnt_r  <= '0;
            err_pend_r <= 1'b0;
        end else begin
            if (accept_s) begin
                wr_r    <= bus.req_write_i;
                addr_r  <= bus.req_addr_i;
                wdata_r <= bus.req_wdata_i;
            end
            if (accept_s)         retry_r <= '0;
            else if (retry_inc_s) retry_r <= retry_r + RW'(1);
            if (next_state_s != state_r) tmo_cnt_r <= '0;
            else if (wait_s)             tmo_cnt_r <= tmo_cnt_r + TW'(1);
            else                         tmo_cnt_r <= '0;
            if (accept_s)       err_pend_r <= 1'b0;
            else if (err_set_s) err_pend_r <= 1'b1;
        end
    end

    // registered outputs
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            idle_r      <= 1'b0;
            rsp_valid_r <= 1'b0;
            rsp_err_r   <= 1'b0;
            stp_r       <= 1'b0;
            data_r      <= NOOP;
            rdata_r     <= 8'h00;
        end else begin
            idle_r      <= (next_state_s == S_IDLE);
            rsp_valid_r <= (next_state_s == S_RESP);
            rsp_err_r   <= (next_state_s == S_RESP) && (err_pend_r || err_set_s);
            stp_r       <= (next_state_s == S_STP);
            data_r      <= data_next_s;
            if (state_r == S_RD_DATA) rdata_r <= bus.ulpi_data_i;
        end
    end

endmodule

// File: tb/tb_oup_ulpi_regaccess.sv
// Bench for oup_ulpi_regaccess with a small behavioural ULPI PHY register file.
module tb_oup_ulpi_regaccess;

    logic clk;
    logic rst_n;

    oup_ulpi_regaccess_if u_if ();

    oup_ulpi_regaccess #(.MAX_RETRY(3), .NXT_TIMEOUT(255)) u_dut (
        .clk_i  (clk),
        .rst_ni (rst_n),
        .bus    (u_if.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_checks = 0;
    int n_errors = 0;

    // PHY-model configuration, written only by the main sequence
    int stall_cfg  = 0;
    int abort_cfg  = 0;
    bit nxt_never  = 1'b0;
    int req_gen    = 0;

    // PHY-model observations, written only by the PHY process
    logic [7:0] bus_q [$];
    int stp_cnt    = 0;
    int cmd_cycles = 0;
    logic [7:0] regs [256];
    bit init_done  = 1'b0;
    int ph         = 0;
    int seen_gen   = 0;
    int stall_cnt  = 0;
    int abort_cnt  = 0;
    bit p_wr       = 1'b0;
    logic [7:0] p_addr = 8'h00;
    logic [7:0] p_wd   = 8'h00;

    // written only by the posedge monitor
    int oe_bad = 0;
    int dir_hi = 0;

    always @(posedge clk) begin
        if (u_if.ulpi_data_oe_o !== !u_if.ulpi_dir_i) oe_bad++;
        if (u_if.ulpi_dir_i) dir_hi++;
    end

    // PHY reacts at the falling edge to what the link shows in this cycle
    always @(negedge clk) begin
        if (!init_done) begin
            for (int i = 0; i < 256; i++) regs[i] = 8'h00;
            regs[0] = 8'hCD;
            regs[1] = 8'hAB;
            init_done = 1'b1;
        end
        if (req_gen != seen_gen) begin
            seen_gen  = req_gen;
            stall_cnt = 0;
            abort_cnt = 0;
        end
        u_if.ulpi_nxt_i = 1'b0;
        if (u_if.ulpi_stp_o === 1'b1) stp_cnt++;
        if (!rst_n) begin
            ph = 0;
            u_if.ulpi_dir_i  = 1'b0;
            u_if.ulpi_data_i = 8'h00;
        end else begin
            case (ph)
                0: begin
                    u_if.ulpi_dir_i  = 1'b0;
                    u_if.ulpi_data_i = 8'h00;
                    if (u_if.ulpi_data_o[7] === 1'b1) begin
                        cmd_cycles++;
                        if (nxt_never) begin
                            ph = 0;
                        end else if (stall_cnt < stall_cfg) begin
                            stall_cnt++;
                        end else begin
                            u_if.ulpi_nxt_i = 1'b1;
                            bus_q.push_back(u_if.ulpi_data_o);
                            p_wr   = !u_if.ulpi_data_o[6];
                            p_addr = {2'b00, u_if.ulpi_data_o[5:0]};
                            if (u_if.ulpi_data_o[5:0] == 6'h2F) ph = 1;
                            else ph = p_wr ? 2 : 3;
                        end
                    end
                end
                1: begin
                    u_if.ulpi_nxt_i = 1'b1;
                    bus_q.push_back(u_if.ulpi_data_o);
                    p_addr = u_if.ulpi_data_o;
                    ph = p_wr ? 2 : 3;
                end
                2: begin
                    if (abort_cnt < abort_cfg) begin
                        abort_cnt++;
                        u_if.ulpi_dir_i = 1'b1;
                        ph = 7;
                    end else begin
                        u_if.ulpi_nxt_i = 1'b1;
                        bus_q.push_back(u_if.ulpi_data_o);
                        p_wd = u_if.ulpi_data_o;
                        ph = 4;
                    end
                end
                4: begin
                    if (u_if.ulpi_stp_o === 1'b1) regs[p_addr] = p_wd;
                    ph = 0;
                end
                3: begin u_if.ulpi_dir_i = 1'b1; ph = 5; end
                5: begin u_if.ulpi_dir_i = 1'b1; u_if.ulpi_data_i = regs[p_addr]; ph = 6; end
                6: begin u_if.ulpi_dir_i = 1'b0; u_if.ulpi_data_i = 8'h00; ph = 0; end
                7: begin u_if.ulpi_dir_i = 1'b1; ph = 8; end
                8: begin u_if.ulpi_dir_i = 1'b0; ph = 0; end
                default: ph = 0;
            endcase
        end
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: actual %0h required %0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(negedge clk);
        #1;
    endtask

    // Issue one request; lat counts cycles from the accepting edge to rsp_valid_o.
    task automatic do_req(input bit wr, input logic [7:0] a, input logic [7:0] d,
                          output int lat, output logic [7:0] rd, output logic er);
        int n;
        req_gen++;
        u_if.req_valid_i = 1'b1;
        u_if.req_write_i = wr;
        u_if.req_addr_i  = a;
        u_if.req_wdata_i = d;
        n = 0;
        while (u_if.req_ready_o !== 1'b1 && n < 20) begin tick(); n++; end
        chk("accept_within_bound", 32'(n < 20), 32'd1);
        tick();
        u_if.req_valid_i = 1'b0;
        lat = 0;
        while (u_if.rsp_valid_o !== 1'b1 && lat < 2000) begin tick(); lat++; end
        rd = u_if.rsp_rdata_o;
        er = u_if.rsp_err_o;
        tick();
        chk("rsp_valid_one_cycle", 32'(u_if.rsp_valid_o), 32'd0);
    endtask

    typedef struct {
        bit         wr;
        logic [7:0] addr;
        logic [7:0] wdata;
        int         nbytes;
        logic [7:0] b0;
        logic [7:0] b1;
        logic [7:0] b2;
        logic [7:0] rdata;
        int         lat;
    } vec_t;

    vec_t vecs [12];

    initial begin
        int lat;
        int base;
        int stp0;
        int cmd0;
        int oe0;
        int dir0;
        int rv_seen;
        logic [7:0] rd;
        logic [7:0] last_rd;
        logic er;
        logic [7:0] eb [3];

        vecs[0]  = '{1'b1, 8'h0A, 8'h55, 2, 8'h8A, 8'h55, 8'h00, 8'h00, 3};
        vecs[1]  = '{1'b0, 8'h00, 8'h00, 1, 8'hC0, 8'h00, 8'h00, 8'hCD, 4};
        vecs[2]  = '{1'b0, 8'h01, 8'h00, 1, 8'hC1, 8'h00, 8'h00, 8'hAB, 4};
        vecs[3]  = '{1'b1, 8'h80, 8'h3C, 3, 8'hAF, 8'h80, 8'h3C, 8'h00, 4};
        vecs[4]  = '{1'b0, 8'h80, 8'h00, 2, 8'hEF, 8'h80, 8'h00, 8'h3C, 5};
        vecs[5]  = '{1'b0, 8'h0A, 8'h00, 1, 8'hCA, 8'h00, 8'h00, 8'h55, 4};
        vecs[6]  = '{1'b1, 8'h2F, 8'h77, 3, 8'hAF, 8'h2F, 8'h77, 8'h00, 4};
        vecs[7]  = '{1'b0, 8'h2F, 8'h00, 2, 8'hEF, 8'h2F, 8'h00, 8'h77, 5};
        vecs[8]  = '{1'b1, 8'h3E, 8'h11, 2, 8'hBE, 8'h11, 8'h00, 8'h00, 3};
        vecs[9]  = '{1'b0, 8'h3E, 8'h00, 1, 8'hFE, 8'h00, 8'h00, 8'h11, 4};
        vecs[10] = '{1'b1, 8'hC1, 8'hA5, 3, 8'hAF, 8'hC1, 8'hA5, 8'h00, 4};
        vecs[11] = '{1'b0, 8'hC1, 8'h00, 2, 8'hEF, 8'hC1, 8'h00, 8'hA5, 5};

        rst_n = 1'b0;
        u_if.req_valid_i = 1'b0;
        u_if.req_write_i = 1'b0;
        u_if.req_addr_i  = 8'h00;
        u_if.req_wdata_i = 8'h00;
        u_if.ulpi_dir_i  = 1'b0;
        u_if.ulpi_nxt_i  = 1'b0;
        u_if.ulpi_data_i = 8'h00;
        last_rd = 8'h00;

        repeat (3) tick();
        chk("reset_req_ready", 32'(u_if.req_ready_o), 32'd0);
        chk("reset_rsp_valid", 32'(u_if.rsp_valid_o), 32'd0);
        chk("reset_rsp_rdata", 32'(u_if.rsp_rdata_o), 32'h00);
        chk("reset_rsp_err",   32'(u_if.rsp_err_o),   32'd0);
        chk("reset_data_o",    32'(u_if.ulpi_data_o), 32'h00);
        chk("reset_stp",       32'(u_if.ulpi_stp_o),  32'd0);
        chk("reset_oe",        32'(u_if.ulpi_data_oe_o), 32'd1);
        rst_n = 1'b1;
        repeat (2) tick();

        for (int i = 0; i < 12; i++) begin
            base = bus_q.size();
            stp0 = stp_cnt;
            do_req(vecs[i].wr, vecs[i].addr, vecs[i].wdata, lat, rd, er);
            chk($sformatf("vec%0d_latency", i), 32'(lat), 32'(vecs[i].lat));
            chk($sformatf("vec%0d_err", i), 32'(er), 32'd0);
            if (vecs[i].wr) begin
                chk($sformatf("vec%0d_rdata_held", i), 32'(rd), 32'(last_rd));
            end else begin
                chk($sformatf("vec%0d_rdata", i), 32'(rd), 32'(vecs[i].rdata));
                last_rd = vecs[i].rdata;
            end
            chk($sformatf("vec%0d_stp_count", i), 32'(stp_cnt - stp0), 32'(vecs[i].wr ? 1 : 0));
            chk($sformatf("vec%0d_bus_bytes", i), 32'(bus_q.size() - base), 32'(vecs[i].nbytes));
            eb[0] = vecs[i].b0;
            eb[1] = vecs[i].b1;
            eb[2] = vecs[i].b2;
            for (int j = 0; j < vecs[i].nbytes; j++) begin
                if (base + j < bus_q.size())
                    chk($sformatf("vec%0d_byte%0d", i, j), 32'(bus_q[base + j]), 32'(eb[j]));
            end
        end

        // nxt held low three cycles on the TX CMD
        stall_cfg = 3;
        base = bus_q.size();
        cmd0 = cmd_cycles;
        do_req(1'b1, 8'h10, 8'h5A, lat, rd, er);
        stall_cfg = 0;
        chk("stall_latency", 32'(lat), 32'd6);
        chk("stall_cmd_cycles", 32'(cmd_cycles - cmd0), 32'd4);
        chk("stall_bus_bytes", 32'(bus_q.size() - base), 32'd2);
        chk("stall_err", 32'(er), 32'd0);

        // one PHY abort during write data
        abort_cfg = 1;
        oe0  = oe_bad;
        dir0 = dir_hi;
        do_req(1'b1, 8'h05, 8'h66, lat, rd, er);
        abort_cfg = 0;
        chk("abort1_latency", 32'(lat), 32'd7);
        chk("abort1_err", 32'(er), 32'd0);
        chk("abort1_dir_cycles", 32'(dir_hi - dir0), 32'd2);
        chk("abort1_oe_follows_dir", 32'(oe_bad - oe0), 32'd0);
        do_req(1'b0, 8'h05, 8'h00, lat, rd, er);
        chk("abort1_readback", 32'(rd), 32'h66);
        last_rd = 8'h66;

        // three aborts still succeed, the fourth exhausts the retries
        abort_cfg = 3;
        do_req(1'b1, 8'h07, 8'h42, lat, rd, er);
        chk("abort3_latency", 32'(lat), 32'd15);
        chk("abort3_err", 32'(er), 32'd0);
        abort_cfg = 4;
        stp0 = stp_cnt;
        do_req(1'b1, 8'h06, 8'h99, lat, rd, er);
        abort_cfg = 0;
        chk("abort4_latency", 32'(lat), 32'd16);
        chk("abort4_err", 32'(er), 32'd1);
        chk("abort4_no_stp", 32'(stp_cnt - stp0), 32'd0);
        chk("abort4_rdata_held", 32'(rd), 32'(last_rd));
        do_req(1'b0, 8'h07, 8'h00, lat, rd, er);
        chk("abort3_readback", 32'(rd), 32'h42);
        chk("after_fail_err_clear", 32'(er), 32'd0);

        // nxt never comes: timeout through a stp pulse
        nxt_never = 1'b1;
        stp0 = stp_cnt;
        base = bus_q.size();
        do_req(1'b1, 8'h08, 8'h12, lat, rd, er);
        nxt_never = 1'b0;
        chk("timeout_latency", 32'(lat), 32'd256);
        chk("timeout_err", 32'(er), 32'd1);
        chk("timeout_stp_pulse", 32'(stp_cnt - stp0), 32'd1);
        chk("timeout_no_bytes", 32'(bus_q.size() - base), 32'd0);

        // reset in the middle of a read
        do_req(1'b0, 8'h01, 8'h00, lat, rd, er);
        chk("pre_reset_read", 32'(rd), 32'hAB);
        u_if.req_valid_i = 1'b1;
        u_if.req_write_i = 1'b0;
        u_if.req_addr_i  = 8'h00;
        begin
            int n;
            n = 0;
            while (u_if.req_ready_o !== 1'b1 && n < 20) begin tick(); n++; end
            chk("midreset_accept", 32'(n < 20), 32'd1);
        end
        tick();
        u_if.req_valid_i = 1'b0;
        repeat (2) tick();
        rst_n = 1'b0;
        #1;
        chk("midreset_req_ready", 32'(u_if.req_ready_o), 32'd0);
        chk("midreset_rsp_valid", 32'(u_if.rsp_valid_o), 32'd0);
        chk("midreset_rsp_rdata", 32'(u_if.rsp_rdata_o), 32'h00);
        chk("midreset_rsp_err",   32'(u_if.rsp_err_o),   32'd0);
        chk("midreset_data_o",    32'(u_if.ulpi_data_o), 32'h00);
        chk("midreset_stp",       32'(u_if.ulpi_stp_o),  32'd0);
        repeat (2) tick();
        rst_n = 1'b1;
        rv_seen = 0;
        for (int k = 0; k < 10; k++) begin
            tick();
            if (u_if.rsp_valid_o === 1'b1) rv_seen++;
        end
        chk("midreset_no_response", 32'(rv_seen), 32'd0);
        do_req(1'b0, 8'h00, 8'h00, lat, rd, er);
        chk("post_reset_read", 32'(rd), 32'hCD);
        chk("post_reset_latency", 32'(lat), 32'd4);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/oup_ulpi_regaccess.md
Name: oup_ulpi_regaccess

Overview:
Link-side ULPI register access engine that sits directly upstream of the PHY on the ULPI bus. It converts single register read and write requests from the link controller into ULPI TX CMD sequences (immediate or extended address), handles the nxt throttle and the dir bus turnaround, and returns read data. It is synthesizable and is the first block that drives oup_phymodel in the bench.

Parameters:
MAX_RETRY, 3, number of re-issues after a PHY abort (dir rising mid-transfer) before reporting failure
NXT_TIMEOUT, 255, cycles to wait for nxt or a dir edge before abandoning with an error

Ports:
clk_i  in  1  ULPI 60 MHz clock; all logic on its rising edge
rst_ni  in  1  reset, asynchronous assert, active-low
req_valid_i  in  1  request present
req_ready_o  out  1  request accepted when valid&&ready
req_write_i  in  1  1=register write, 0=register read
req_addr_i  in  8  register address
req_wdata_i  in  8  write data
rsp_valid_o  out  1  one-cycle pulse when a request completes
rsp_rdata_o  out  8  read data; valid with rsp_valid_o and held until the next response
rsp_err_o  out  1  with rsp_valid_o: retries exhausted or timeout
ulpi_dir_i  in  1  PHY owns the bus when 1
ulpi_nxt_i  in  1  PHY throttle
ulpi_data_i  in  8  bus input
ulpi_data_o  out  8  bus output
ulpi_data_oe_o  out  1  output enable, =!ulpi_dir_i (combinational)
ulpi_stp_o  out  1  stop

Behaviour:
- Reset values: req_ready_o=0, rsp_valid_o=0, rsp_rdata_o=8'h00, rsp_err_o=0, ulpi_data_o=8'h00, ulpi_stp_o=0. State=S_IDLE, retry and timeout counters=0. Reset mid-operation abandons the transfer and produces no response.
- Extended addressing applies when req_addr_i[7:6]!=0 or req_addr_i[5:0]==6'h2F. The TX CMD then carries the address field 6'h2F, and the full address follows in its own cycle.
- TX CMD encoding: write = {2'b10, a[5:0]}; read = {2'b11, a[5:0]}.
- S_IDLE: ulpi_data_o=8'h00 (NOOP). req_ready_o=1 only when ulpi_dir_i=0. On accept, latch write, addr and wdata, then go to S_CMD.
- S_CMD: drive the TX CMD and hold it until nxt=1. The next state is S_EXTADDR if extended, else S_WDATA (write) or S_RD_TURN (read).
- S_EXTADDR: drive the full address and hold it until nxt=1. The next state is S_WDATA or S_RD_TURN.
- S_WDATA: drive wdata and hold it until nxt=1, then go to S_STP.
- S_STP: ulpi_stp_o=1 and ulpi_data_o=8'h00 for exactly one cycle. Then go to S_RESP.
- S_RD_TURN: drive 8'h00 and wait for dir=1. The cycle in which dir is first seen high is the turnaround and is not sampled. Then go to S_RD_DATA.
- S_RD_DATA: capture ulpi_data_i into rsp_rdata_o, then go to S_RD_BACK.
- S_RD_BACK: wait for dir=0. The first dir=0 cycle is the turnaround. Then go to S_RESP.
- S_RESP: rsp_valid_o=1 for one cycle, then go to S_IDLE. Best-case latency from accept to rsp_valid_o (nxt and dir react immediately): write 3 cycles (4 if extended), read 4 cycles (5 if extended).
- Abort: dir rising while in S_CMD, S_EXTADDR or S_WDATA means the PHY is sending an RX CMD.
  - Stop driving, go to S_ABORT and wait for dir=0.
  - If the retry count is below MAX_RETRY, increment it and return to S_CMD with the latched request.
  - Otherwise go to S_RESP with rsp_err_o=1.
  - dir rising together with nxt in the same cycle counts as an abort; the nxt is ignored.
- Timeout: the counter clears on every state change and counts cycles spent in any wait state. When it reaches NXT_TIMEOUT, go to S_RESP with rsp_err_o=1; for reads rsp_rdata_o is left unchanged. Transfers from S_CMD, S_EXTADDR or S_WDATA first pass through S_STP.
- Only one request is outstanding at a time; req_ready_o=0 outside S_IDLE.

Decomposition:
- Package oup_ulpi_pkg holds:
  - TXCMD_REGW=2'b10 and TXCMD_REGR=2'b11
  - EXT_ADDR_CODE=6'h2F
  - NOOP=8'h00
  - the state typedef regaccess_state_t
- No sub-module. The retry and timeout counters stay inline.

Test Plan:
- Write 8'h0A←8'h55 against oup_phymodel with nxt immediate -> bus shows 8'h8A, 8'h55, then stp with 8'h00; rsp_valid_o 3 cycles after accept; rsp_err_o=0.
- Read 8'h00 (VID_L) -> bus shows 8'hC0; rsp_rdata_o=8'hCD with rsp_valid_o. Read 8'h01 -> 8'hAB.
- Extended write addr 8'h80 data 8'h3C -> bus shows 8'hAF, 8'h80, 8'h3C, stp; a subsequent extended read of 8'h80 returns 8'h3C.
- nxt held low for 3 cycles in S_CMD -> TX CMD stays on the bus for 4 cycles; no early data; total write latency 6.
- Force dir=1 for 2 cycles during S_WDATA -> ulpi_data_oe_o=0, the transfer restarts with the TX CMD, completes with rsp_err_o=0. Repeat the abort 4 times -> rsp_err_o=1.
- Hold nxt=0 for 300 cycles -> stp pulse, then rsp_valid_o with rsp_err_o=1 after 255 wait cycles. Assert rst_ni low mid-read -> all outputs at reset values, no rsp_valid_o.
